// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, the rejection-sampler FSM encoding and a counter clamp helper.
package dilithium_pkg;

   localparam int N                    = 256;
   localparam int Q                    = 8380417;
   localparam int SHAKE128_RATE        = 168;
   localparam int POLY_UNIFORM_NBLOCKS = 5;
   localparam int BUFLEN_MAX           = POLY_UNIFORM_NBLOCKS * SHAKE128_RATE + 2;
   localparam int BUF_BITS             = 8 * BUFLEN_MAX;

   // The buffer is viewed as whole 3-byte triples; the last triple is zero-padded.
   localparam int NTRIPLES = (BUF_BITS + 23) / 24;
   localparam int PAD_BITS = NTRIPLES * 24 - BUF_BITS;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [8:0] N_CTR = 9'(N);

   // An out-of-range starting count behaves as a full polynomial.
   function automatic logic [8:0] clamp_ctr(input logic [8:0] c);
      return (c > N_CTR) ? N_CTR : c;
   endfunction

endpackage

// File: rtl/rej_uniform_triple.sv
// Combinational candidate extraction: 3 little-endian bytes, top bit masked, accept iff t < Q.
module rej_uniform_triple
   import dilithium_pkg::*;
(
   input  logic [23:0] triple,
   output logic [22:0] t,
   output logic        accept
);

   assign t      = triple[22:0];
   assign accept = (t < 23'(Q));

endmodule

// File: rtl/rej_uniform_sampler.sv
// Dilithium poly_uniform rejection sampler: scans one byte triple per cycle, writes accepted coefficients.
// Optional macro REJ_UNIFORM_REJCNT_EN adds the rej_count output.
module rej_uniform_sampler
   import dilithium_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [BUF_BITS-1:0] buf_in,
   input  logic [9:0]          buflen,
   input  logic [8:0]          ctr_in,
   output logic                busy,
   output logic                coef_we,
   output logic [7:0]          coef_addr,
   output logic [22:0]         coef_data,
   output logic [8:0]          ctr_out,
   output logic [9:0]          pos_out,
   output logic                done
`ifdef REJ_UNIFORM_REJCNT_EN
   ,
   output logic [9:0]          rej_count
`endif
);

   logic [1:0]                  state_q;
   logic [9:0]                  pos_q;
   logic [8:0]                  tidx_q;
   logic [8:0]                  ctr_q;
   logic [9:0]                  buflen_q;
   logic [NTRIPLES-1:0][23:0]   trip_q;

   logic        stop;
   logic        eval;
   logic        accept;
   logic [22:0] t;
   logic        launch;

   assign launch = (state_q == ST_IDLE) && start;
   assign stop   = (ctr_q == N_CTR) || (({1'b0, pos_q} + 11'd3) > {1'b0, buflen_q});
   assign eval   = (state_q == ST_SCAN) && !stop;
   assign busy   = (state_q == ST_SCAN) || (state_q == ST_DONE);

   rej_uniform_triple u_triple (
      .triple (trip_q[tidx_q]),
      .t      (t),
      .accept (accept)
   );

   // Input capture: data only, held for the whole scan so the caller may change buf_in.
   always_ff @(posedge clock) begin
      if (launch) begin
         trip_q   <= {{PAD_BITS{1'b0}}, buf_in};
         buflen_q <= buflen;
      end
   end

   // Control FSM and registered write port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pos_q     <= '0;
         tidx_q    <= '0;
         ctr_q     <= '0;
         coef_we   <= 1'b0;
         coef_addr <= '0;
         coef_data <= '0;
         ctr_out   <= '0;
         pos_out   <= '0;
         done      <= 1'b0;
      end else begin
         done    <= 1'b0;
         coef_we <= eval && accept;
         if (eval && accept) begin
            coef_addr <= ctr_q[7:0];
            coef_data <= t;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_SCAN;
                  pos_q   <= '0;
                  tidx_q  <= '0;
                  ctr_q   <= clamp_ctr(ctr_in);
               end
            end
            ST_SCAN: begin
               if (stop) begin
                  state_q <= ST_DONE;
               end else begin
                  pos_q  <= pos_q + 10'd3;
                  tidx_q <= tidx_q + 9'd1;
                  if (accept) ctr_q <= ctr_q + 9'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done    <= 1'b1;
               ctr_out <= ctr_q;
               pos_out <= pos_q;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef REJ_UNIFORM_REJCNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rej_count <= '0;
      end else if (launch) begin
         rej_count <= '0;
      end else if (eval && !accept) begin
         rej_count <= rej_count + 10'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Randomized bench for rej_uniform_sampler against a byte-level reference of poly_uniform rejection sampling.
module tb_rej_uniform_sampler;

   localparam int NC    = 256;
   localparam int QREF  = 8380417;
   localparam int BITS  = 6736;
   localparam int MAXB  = 842;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [BITS-1:0]  buf_in;
   logic [9:0]       buflen;
   logic [8:0]       ctr_in;
   logic             busy;
   logic             coef_we;
   logic [7:0]       coef_addr;
   logic [22:0]      coef_data;
   logic [8:0]       ctr_out;
   logic [9:0]       pos_out;
   logic             done;
`ifdef REJ_UNIFORM_REJCNT_EN
   logic [9:0]       rej_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   rej_uniform_sampler dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .buf_in    (buf_in),
      .buflen    (buflen),
      .ctr_in    (ctr_in),
      .busy      (busy),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .ctr_out   (ctr_out),
      .pos_out   (pos_out),
      .done      (done)
`ifdef REJ_UNIFORM_REJCNT_EN
      ,
      .rej_count (rej_count)
`endif
   );

   task automatic check(input string tag, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [BITS-1:0] rand_bits();
      logic [BITS-1:0] r;
      for (int i = 0; i < BITS; i += 32) r[i +: 32] = $urandom();
      return r;
   endfunction

   // Bytes biased so that a useful fraction of candidates land at or above Q.
   function automatic logic [BITS-1:0] rand_buf();
      logic [BITS-1:0] r;
      r = '0;
      for (int i = 0; i < MAXB; i++) begin
         if (i % 3 != 0 && $urandom_range(0, 2) == 0)
            r[8*i +: 8] = 8'hE0 | 8'($urandom_range(0, 31)) | ((i % 3 == 2) ? 8'h7F : 8'h00);
         else
            r[8*i +: 8] = 8'($urandom());
      end
      return r;
   endfunction

   task automatic run_case(input string name, input logic [BITS-1:0] b, input int blen,
                           input int cin, input bit poke);
      int exp_addr[$];
      int exp_data[$];
      int ctr, pos, rej, ntrip, cand, got_done;
      ctr = (cin > NC) ? NC : cin;
      pos = 0;
      rej = 0;
      ntrip = 0;
      while (ctr < NC && pos + 3 <= blen) begin
         cand = int'(b[8*pos +: 8]) + 256 * int'(b[8*pos+8 +: 8])
              + 65536 * int'(b[8*pos+16 +: 8] & 8'h7F);
         if (cand < QREF) begin
            exp_addr.push_back(ctr);
            exp_data.push_back(cand);
            ctr++;
         end else begin
            rej++;
         end
         pos += 3;
         ntrip++;
      end

      @(negedge clock);
      buf_in = b;
      buflen = 10'(blen);
      ctr_in = 9'(cin);
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (poke) begin
         buf_in = rand_bits();
         buflen = 10'($urandom());
         ctr_in = 9'($urandom_range(0, 20));
      end
      check({name, ".busy"}, busy, 1);
      got_done = 0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(posedge clock);
         #1;
         if (coef_we) begin
            if (exp_addr.size() == 0) begin
               check({name, ".extra_we"}, 1, 0);
            end else begin
               check({name, ".addr"}, coef_addr, exp_addr.pop_front());
               check({name, ".data"}, coef_data, exp_data.pop_front());
            end
         end
         start = poke && (cyc == 1);
         if (done) begin
            got_done = cyc;
            break;
         end
      end
      start = 1'b0;
      check({name, ".done_seen"}, (got_done != 0), 1);
      check({name, ".latency"}, got_done, ntrip + 2);
      check({name, ".missing_we"}, exp_addr.size(), 0);
      check({name, ".ctr_out"}, ctr_out, ctr);
      check({name, ".pos_out"}, pos_out, pos);
`ifdef REJ_UNIFORM_REJCNT_EN
      check({name, ".rej_count"}, rej_count, rej);
`endif
      @(posedge clock);
      #1;
      check({name, ".idle_after"}, busy, 0);
      check({name, ".ctr_out_held"}, ctr_out, ctr);
   endtask

   initial begin
      logic [BITS-1:0] b;
      reset  = 1'b1;
      start  = 1'b0;
      buf_in = '0;
      buflen = '0;
      ctr_in = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst.busy", busy, 0);
      check("rst.we", coef_we, 0);
      check("rst.done", done, 0);
      check("rst.ctr_out", ctr_out, 0);
      check("rst.pos_out", pos_out, 0);
      @(negedge clock);
      reset = 1'b0;

      b = '0;
      b[8*3 +: 24] = 24'hFFFFFF;
      run_case("one_of_two", b, 6, 0, 0);

      b = '0;
      b[0 +: 24]    = 24'h7FE000;
      b[24 +: 24]   = 24'h7FE001;
      b[48 +: 24]   = 24'h800001;
      run_case("q_edges", b, 9, 0, 0);

      run_case("zero_full", '0, 840, 0, 0);
      run_case("zero_ctr250", '0, 840, 250, 0);
      run_case("short_buf", rand_buf(), 2, 17, 1);
      run_case("ctr_over_n", '0, 30, 300, 0);
      run_case("empty_buf", rand_buf(), 0, 0, 1);

      b = '0;
      b[0 +: 72] = {72{1'b1}};
      run_case("all_reject", b, 9, 5, 0);

      run_case("rand_full", rand_buf(), 842, 0, 1);
      for (int k = 0; k < 10; k++) begin
         int cin;
         cin = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(200, 260);
         run_case("rand", rand_buf(), $urandom_range(0, MAXB), cin, k[0]);
      end

      // Reset in the middle of a long scan.
      @(negedge clock);
      buf_in = '0;
      buflen = 10'd840;
      ctr_in = '0;
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check("mid.busy_before", busy, 1);
      reset = 1'b1;
      #1;
      check("mid.we", coef_we, 0);
      check("mid.busy", busy, 0);
      check("mid.addr", coef_addr, 0);
      check("mid.data", coef_data, 0);
      check("mid.ctr_out", ctr_out, 0);
      check("mid.pos_out", pos_out, 0);
`ifdef REJ_UNIFORM_REJCNT_EN
      check("mid.rej_count", rej_count, 0);
`endif
      @(negedge clock);
      reset = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(posedge clock);
         #1;
         check("post_rst.we", coef_we, 0);
         check("post_rst.done", done, 0);
         check("post_rst.busy", busy, 0);
      end
      run_case("after_reset", rand_buf(), 120, 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
